// File: rtl/compute_dispatch_controller.sv
// Dispatch controller for one compute module: pops bots from upstream on module
// requests, tags each issue, and totals the returned connected counts per batch.
module compute_dispatch_controller #(
    parameter int EXTRA_DATA_WIDTH = 14,
    parameter int REQUEST_LATENCY  = 3,
    parameter int BATCH_WIDTH      = 16,
    parameter int INFLIGHT_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_start,
    input  logic                        cmd_abort,
    input  logic [BATCH_WIDTH-1:0]      batch_size,
    input  logic                        bot_valid,
    input  logic [127:0]                bot_data,
    output logic                        bot_ready,
    input  logic                        requestGraph,
    output logic [127:0]                botIn,
    output logic                        start,
    output logic [EXTRA_DATA_WIDTH-1:0] extraDataIn,
    input  logic                        done,
    input  logic [5:0]                  resultCount,
    input  logic [EXTRA_DATA_WIDTH-1:0] extraDataOut,
    output logic                        result_valid,
    output logic [5:0]                  result_count,
    output logic [EXTRA_DATA_WIDTH-1:0] result_tag,
    output logic                        busy,
    output logic                        batch_done,
    output logic [BATCH_WIDTH+5:0]      batch_sum,
    output logic [BATCH_WIDTH-1:0]      batch_issued
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_REPORT} state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        w_issue;
    logic                        w_dec;
    logic                        w_pipe_busy;
    logic [BATCH_WIDTH-1:0]      w_issued_inc;
    logic [BATCH_WIDTH-1:0]      r_size;
    logic [BATCH_WIDTH-1:0]      r_issued;
    logic [EXTRA_DATA_WIDTH-1:0] r_tag;
    logic [INFLIGHT_WIDTH-1:0]   r_inflight;
    logic [BATCH_WIDTH+5:0]      r_sum;
    logic [REQUEST_LATENCY-1:0]  r_pipe_vld;
    logic [EXTRA_DATA_WIDTH-1:0] r_pipe_tag  [REQUEST_LATENCY];
    logic [127:0]                r_pipe_data [REQUEST_LATENCY];
    logic                        r_result_valid;
    logic [5:0]                  r_result_count;
    logic [EXTRA_DATA_WIDTH-1:0] r_result_tag;
    logic                        r_batch_done;
    logic [BATCH_WIDTH+5:0]      r_batch_sum;
    logic [BATCH_WIDTH-1:0]      r_batch_issued;

    assign w_issued_inc = r_issued + BATCH_WIDTH'(1);
    assign w_pipe_busy  = |r_pipe_vld;
    assign w_dec        = done && (r_inflight != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (cmd_start) w_state_next = (batch_size == '0) ? S_REPORT : S_RUN;
            S_RUN:    if (cmd_abort || (w_issue && (w_issued_inc == r_size))) w_state_next = S_DRAIN;
            S_DRAIN:  if ((r_inflight == '0) && !w_pipe_busy) w_state_next = S_REPORT;
            S_REPORT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // An abort in the same cycle suppresses the pop; the upstream bot stays put.
    always_comb begin
        w_issue = rst && requestGraph && bot_valid && (r_state == S_RUN)
                  && (r_issued < r_size) && !cmd_abort;
        busy    = (r_state != S_IDLE);
    end

    assign bot_ready = w_issue;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_size         <= '0;
            r_issued       <= '0;
            r_tag          <= '0;
            r_inflight     <= '0;
            r_sum          <= '0;
            r_pipe_vld     <= '0;
            r_result_valid <= 1'b0;
            r_result_count <= '0;
            r_result_tag   <= '0;
            r_batch_done   <= 1'b0;
            r_batch_sum    <= '0;
            r_batch_issued <= '0;
            for (int i = 0; i < REQUEST_LATENCY; i++) begin
                r_pipe_tag[i]  <= '0;
                r_pipe_data[i] <= '0;
            end
        end else begin
            if ((r_state == S_IDLE) && cmd_start) begin
                r_size         <= batch_size;
                r_issued       <= '0;
                r_tag          <= '0;
                r_sum          <= '0;
                r_batch_sum    <= '0;
                r_batch_issued <= '0;
            end else begin
                if (w_issue) begin
                    r_issued <= w_issued_inc;
                    r_tag    <= r_tag + EXTRA_DATA_WIDTH'(1);
                end
                if (done) r_sum <= r_sum + {{BATCH_WIDTH{1'b0}}, resultCount};
            end

            case ({w_issue, w_dec})
                2'b10:   r_inflight <= r_inflight + INFLIGHT_WIDTH'(1);
                2'b01:   r_inflight <= r_inflight - INFLIGHT_WIDTH'(1);
                default: r_inflight <= r_inflight;
            endcase

            // Bubbles travel through the delay line with start=0 so slot timing is kept.
            r_pipe_vld[0]  <= w_issue;
            r_pipe_tag[0]  <= r_tag;
            r_pipe_data[0] <= bot_data;
            for (int i = 1; i < REQUEST_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_tag[i]  <= r_pipe_tag[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end

            r_result_valid <= done;
            r_result_count <= resultCount;
            r_result_tag   <= extraDataOut;

            r_batch_done <= (r_state == S_REPORT);
            if (r_state == S_REPORT) begin
                r_batch_sum    <= r_sum;
                r_batch_issued <= r_issued;
            end
        end
    end

    assign start        = r_pipe_vld[REQUEST_LATENCY-1];
    assign extraDataIn  = r_pipe_tag[REQUEST_LATENCY-1];
    assign botIn        = r_pipe_data[REQUEST_LATENCY-1];
    assign result_valid = r_result_valid;
    assign result_count = r_result_count;
    assign result_tag   = r_result_tag;
    assign batch_done   = r_batch_done;
    assign batch_sum    = r_batch_sum;
    assign batch_issued = r_batch_issued;

endmodule

// File: tb/tb_compute_dispatch_controller.sv
// Bench for compute_dispatch_controller: table of batch scenarios, hand sequences for
// tag wrap and mid-batch reset, and random batches against a transaction-level model.
module tb_compute_dispatch_controller;

    localparam int XW  = 14;
    localparam int LAT = 3;
    localparam int BW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_abort = 1'b0;
    logic [BW-1:0] batch_size = '0;
    logic          bot_valid = 1'b0;
    logic [127:0]  bot_data = '0;
    logic          requestGraph = 1'b0;
    logic          done = 1'b0;
    logic [5:0]    resultCount = '0;
    logic [XW-1:0] extraDataOut = '0;
    logic [1:0]    d2_xdo;
    assign d2_xdo = extraDataOut[1:0];

    logic          bot_ready, start, result_valid, busy, batch_done;
    logic [127:0]  botIn;
    logic [XW-1:0] extraDataIn, result_tag;
    logic [5:0]    result_count;
    logic [BW+5:0] batch_sum;
    logic [BW-1:0] batch_issued;

    logic          d2_bot_ready, d2_start, d2_result_valid, d2_busy, d2_batch_done;
    logic [127:0]  d2_botIn;
    logic [1:0]    d2_extraDataIn, d2_result_tag;
    logic [5:0]    d2_result_count;
    logic [BW+5:0] d2_batch_sum;
    logic [BW-1:0] d2_batch_issued;

    compute_dispatch_controller #(.EXTRA_DATA_WIDTH(XW), .REQUEST_LATENCY(LAT),
                                  .BATCH_WIDTH(BW), .INFLIGHT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .batch_size(batch_size), .bot_valid(bot_valid), .bot_data(bot_data),
        .bot_ready(bot_ready), .requestGraph(requestGraph), .botIn(botIn), .start(start),
        .extraDataIn(extraDataIn), .done(done), .resultCount(resultCount),
        .extraDataOut(extraDataOut), .result_valid(result_valid), .result_count(result_count),
        .result_tag(result_tag), .busy(busy), .batch_done(batch_done),
        .batch_sum(batch_sum), .batch_issued(batch_issued));

    compute_dispatch_controller #(.EXTRA_DATA_WIDTH(2), .REQUEST_LATENCY(LAT),
                                  .BATCH_WIDTH(BW), .INFLIGHT_WIDTH(8)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .batch_size(batch_size), .bot_valid(bot_valid), .bot_data(bot_data),
        .bot_ready(d2_bot_ready), .requestGraph(requestGraph), .botIn(d2_botIn), .start(d2_start),
        .extraDataIn(d2_extraDataIn), .done(done), .resultCount(resultCount),
        .extraDataOut(d2_xdo), .result_valid(d2_result_valid), .result_count(d2_result_count),
        .result_tag(d2_result_tag), .busy(d2_busy), .batch_done(d2_batch_done),
        .batch_sum(d2_batch_sum), .batch_issued(d2_batch_issued));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: batch bookkeeping plus queues of expected presentations/results.
    typedef struct {int cyc; int tag; logic [127:0] data;} pres_t;
    typedef struct {int cyc; int tag; int cnt;} res_t;
    pres_t pq[$];
    res_t  rq[$];
    int    m_phase = 0;   // 0 idle, 1 run, 2 drain, 3 report
    int    m_size = 0, m_issued = 0, m_tag = 0, m_sum = 0, m_out = 0;
    logic  e_busy = 1'b0, e_bdone = 1'b0, e_rv = 1'b0;
    int    e_bsum = 0, e_bissued = 0, e_rc = 0, e_rt = 0;
    int    res_lat = 20;
    int    res_cnt_fixed = 3;
    bit    collect_d2 = 1'b0;
    int    d2_tags[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic  exp_ready, issue, dec, exp_start;
        int    nphase, cnt;
        pres_t p;
        done = 1'b0; resultCount = '0; extraDataOut = '0;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            done = 1'b1;
            resultCount = 6'(rq[0].cnt);
            extraDataOut = XW'(rq[0].tag);
            void'(rq.pop_front());
        end
        #1;
        exp_ready = rst && requestGraph && bot_valid && (m_phase == 1)
                    && (m_issued < m_size) && !cmd_abort;
        check("bot_ready", bot_ready, exp_ready);
        check("d2_bot_ready", d2_bot_ready, exp_ready);
        issue = exp_ready;
        if (!rst) begin
            m_phase = 0; m_size = 0; m_issued = 0; m_tag = 0; m_sum = 0; m_out = 0;
            pq.delete(); rq.delete();
            e_busy = 0; e_bdone = 0; e_bsum = 0; e_bissued = 0; e_rv = 0; e_rc = 0; e_rt = 0;
        end else begin
            nphase  = m_phase;
            dec     = done && (m_out > 0);
            e_bdone = (m_phase == 3);
            e_rv = done; e_rc = int'(resultCount); e_rt = int'(extraDataOut);
            case (m_phase)
                0: if (cmd_start) begin
                    nphase = (batch_size == '0) ? 3 : 1;
                    m_size = int'(batch_size); m_issued = 0; m_tag = 0; m_sum = 0;
                    e_bsum = 0; e_bissued = 0;
                end
                1: if (cmd_abort || (issue && m_issued + 1 == m_size)) nphase = 2;
                2: if (m_out == 0) nphase = 3;
                default: begin nphase = 0; e_bsum = m_sum; e_bissued = m_issued; end
            endcase
            if (done && !(m_phase == 0 && cmd_start)) m_sum += int'(resultCount);
            if (issue) begin
                p.cyc = cyc + LAT; p.tag = m_tag; p.data = bot_data;
                pq.push_back(p);
                m_issued++;
                m_tag = (m_tag + 1) % (1 << XW);
            end
            m_out = m_out + (issue ? 1 : 0) - (dec ? 1 : 0);
            m_phase = nphase;
            e_busy = (nphase != 0);
        end
        @(posedge clk); #1;
        cyc++;
        exp_start = (pq.size() > 0) && (pq[0].cyc == cyc);
        check("start", start, exp_start);
        check("d2_start", d2_start, exp_start);
        if (exp_start) begin
            check("extraDataIn", extraDataIn, pq[0].tag);
            check("botIn", botIn, pq[0].data);
            check("d2_extraDataIn", d2_extraDataIn, pq[0].tag % 4);
            check("d2_botIn", d2_botIn, pq[0].data);
            cnt = (res_cnt_fixed >= 0) ? res_cnt_fixed : int'($urandom_range(0, 63));
            rq.push_back('{cyc + res_lat, pq[0].tag, cnt});
            void'(pq.pop_front());
        end
        if (collect_d2 && d2_start) d2_tags.push_back(int'(d2_extraDataIn));
        check("result_valid", result_valid, e_rv);
        check("result_count", result_count, e_rc);
        check("result_tag", result_tag, e_rt);
        check("busy", busy, e_busy);
        check("batch_done", batch_done, e_bdone);
        check("batch_sum", batch_sum, e_bsum);
        check("batch_issued", batch_issued, e_bissued);
        check("d2_result_valid", d2_result_valid, e_rv);
        check("d2_result_count", d2_result_count, e_rc);
        check("d2_result_tag", d2_result_tag, e_rt % 4);
        check("d2_busy", d2_busy, e_busy);
        check("d2_batch_done", d2_batch_done, e_bdone);
        check("d2_batch_sum", d2_batch_sum, e_bsum);
        check("d2_batch_issued", d2_batch_issued, e_bissued);
    endtask

    task automatic run_batch(input int size, input logic [31:0] bub, input int abort_idx,
                             input int cnt, input int lat, input bit rnd,
                             output int got_sum, output int got_issued, output int got_k);
        bit seen;
        seen = 1'b0; got_sum = -1; got_issued = -1; got_k = -1;
        res_cnt_fixed = cnt; res_lat = lat;
        cmd_start = 1'b1; batch_size = BW'(size); requestGraph = 1'b0; bot_valid = 1'b0;
        cmd_abort = 1'b0;
        cycle();
        cmd_start = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (rnd) begin
                requestGraph = ($urandom_range(0, 4) != 0);
                bot_valid    = ($urandom_range(0, 3) != 0);
                cmd_abort    = ($urandom_range(0, 39) == 0);
                cmd_start    = ($urandom_range(0, 19) == 0);
                batch_size   = BW'($urandom_range(0, 50));
            end else begin
                requestGraph = 1'b1;
                bot_valid    = (k < 32) ? !bub[k] : 1'b1;
                cmd_abort    = (k == abort_idx);
            end
            bot_data = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            if (batch_done) begin
                seen = 1'b1; got_sum = int'(batch_sum); got_issued = int'(batch_issued); got_k = k;
            end
        end
        cmd_start = 1'b0; cmd_abort = 1'b0; requestGraph = 1'b0; bot_valid = 1'b0;
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL batch_timeout: batch_done never seen, size=%0d required within 400 cycles", size);
        end
    endtask

    typedef struct {
        int size; logic [31:0] bub; int abort_idx; int cnt; int lat;
        int exp_issued; int exp_sum; int exp_k;
    } vec_t;
    vec_t tbl[6];
    int   wrap_exp[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, is, k;
        tbl[0] = '{4,  32'h0, -1, 3,  20, 4, 12,  -1};
        tbl[1] = '{0,  32'h0, -1, 5,  4,  0, 0,   0};
        tbl[2] = '{5,  32'h6, -1, 2,  6,  5, 10,  -1};
        tbl[3] = '{10, 32'h0, 2,  5,  8,  2, 10,  -1};
        tbl[4] = '{8,  32'h0, -1, 1,  1,  8, 8,   -1};
        tbl[5] = '{3,  32'h0, -1, 63, 2,  3, 189, -1};
        wrap_exp = '{0, 1, 2, 3, 0, 1};

        rst = 1'b0;
        cycle(); cycle();
        check("reset_busy", busy, 1'b0);
        check("reset_start", start, 1'b0);
        check("reset_botIn", botIn, 128'h0);
        check("reset_batch_sum", batch_sum, 0);
        rst = 1'b1;
        cycle();

        for (int i = 0; i < 6; i++) begin
            run_batch(tbl[i].size, tbl[i].bub, tbl[i].abort_idx, tbl[i].cnt, tbl[i].lat, 1'b0,
                      s, is, k);
            check($sformatf("tbl%0d_issued", i), is, tbl[i].exp_issued);
            check($sformatf("tbl%0d_sum", i), s, tbl[i].exp_sum);
            if (tbl[i].exp_k >= 0) check($sformatf("tbl%0d_done_delay", i), k, tbl[i].exp_k);
            cycle();
            check($sformatf("tbl%0d_idle", i), busy, 1'b0);
        end

        d2_tags.delete();
        collect_d2 = 1'b1;
        run_batch(6, 32'h0, -1, 1, 5, 1'b0, s, is, k);
        collect_d2 = 1'b0;
        cycle();
        check("wrap_count", d2_tags.size(), 6);
        for (int i = 0; i < 6 && i < d2_tags.size(); i++)
            check($sformatf("wrap_tag%0d", i), d2_tags[i], wrap_exp[i]);

        res_cnt_fixed = 1; res_lat = 20;
        cmd_start = 1'b1; batch_size = BW'(10);
        cycle();
        cmd_start = 1'b0; requestGraph = 1'b1; bot_valid = 1'b1;
        bot_data = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        bot_data = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1; requestGraph = 1'b0; bot_valid = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_botIn", botIn, 128'h0);
        check("midrst_extraDataIn", extraDataIn, 0);
        check("midrst_result_tag", result_tag, 0);
        check("midrst_batch_issued", batch_issued, 0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("midrst_no_start", start, 1'b0);
        end
        run_batch(3, 32'h0, -1, 4, 3, 1'b0, s, is, k);
        check("postrst_issued", is, 3);
        check("postrst_sum", s, 12);
        cycle();

        for (int i = 0; i < 8; i++) begin
            run_batch(int'($urandom_range(1, 12)), 32'h0, -1, -1, int'($urandom_range(1, 6)),
                      1'b1, s, is, k);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
